// File: rtl/vend_pkg.sv
// Shared vending constants: FSM state encoding, one-hot coin codes and coin value widths.
// The product-code-to-price lookup stage uses the same coin code constants.
package vend_pkg;

    typedef enum logic [1:0] {
        ST_IDLE     = 2'd0,
        ST_COLLECT  = 2'd1,
        ST_DISPENSE = 2'd2,
        ST_CHANGE   = 2'd3
    } state_t;

    localparam int COIN_CODE_W = 4;
    localparam int COIN_VAL_W  = 4;

    localparam logic [COIN_CODE_W-1:0] COIN_1  = 4'b0001;
    localparam logic [COIN_CODE_W-1:0] COIN_2  = 4'b0010;
    localparam logic [COIN_CODE_W-1:0] COIN_5  = 4'b0100;
    localparam logic [COIN_CODE_W-1:0] COIN_10 = 4'b1000;

endpackage

// File: rtl/vend_coin_decode.sv
// Combinational one-hot coin code to {valid, value} decoder.
// Zero latency, no flow control; any non-listed code decodes as invalid with value 0.
module vend_coin_decode
    import vend_pkg::*;
(
    input  logic [COIN_CODE_W-1:0] code,
    output logic                   valid,
    output logic [COIN_VAL_W-1:0]  value
);

    always_comb begin
        valid = 1'b1;
        value = '0;
        case (code)
            COIN_1:  value = 4'd1;
            COIN_2:  value = 4'd2;
            COIN_5:  value = 4'd5;
            COIN_10: value = 4'd10;
            default: valid = 1'b0;
        endcase
    end

endmodule

// File: rtl/vend_payment_fsm.sv
// Vending payment FSM: latches price, credits coins, pulses dispense then change/refund.
// Outputs registered, one-cycle response, no backpressure; VEND_TIMEOUT_EN adds a COLLECT inactivity refund.
module vend_payment_fsm
    import vend_pkg::*;
#(
    parameter int unsigned TIMEOUT_CYCLES = 1024
)
(
    input  logic                   clk,
    input  logic                   rst_n,
    input  logic [7:0]             product_price,
    input  logic                   sel_valid,
    input  logic                   coin_valid,
    input  logic [COIN_CODE_W-1:0] coin_code,
    input  logic                   cancel,
    output logic                   busy,
    output logic [7:0]             price_lat,
    output logic [7:0]             balance,
    output logic                   dispense,
    output logic                   change_valid,
    output logic [7:0]             change_amt,
    output logic                   sel_err,
    output logic                   coin_rej
);

    state_t                  state, state_n;
    logic [7:0]              bal_n, price_n, chg_n;
    logic                    sel_err_n, coin_rej_n;
    logic                    dec_valid;
    logic [COIN_VAL_W-1:0]   dec_value;
    logic [8:0]              sum;
    logic                    coin_ok, credit, timeout;

    vend_coin_decode u_coin_decode (
        .code  (coin_code),
        .valid (dec_valid),
        .value (dec_value)
    );

    // 9-bit sum: bit 8 flags a credit that would overflow the 8-bit balance.
    assign sum     = {1'b0, balance} + {{(9-COIN_VAL_W){1'b0}}, dec_value};
    assign coin_ok = coin_valid & dec_valid & ~sum[8];
    assign credit  = (state == ST_COLLECT) & coin_ok & ~cancel;

`ifdef VEND_TIMEOUT_EN
    localparam int unsigned      CW       = $clog2(TIMEOUT_CYCLES);
    localparam logic [CW-1:0]    CNT_LAST = CW'(TIMEOUT_CYCLES - 1);
    logic [CW-1:0]               idle_cnt, idle_cnt_n;

    // A credited coin in the terminal-count cycle restarts the count instead of timing out.
    assign timeout    = (state == ST_COLLECT) && (idle_cnt == CNT_LAST) && !credit;
    assign idle_cnt_n = ((state == ST_COLLECT) && !credit) ? idle_cnt + 1'b1 : '0;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) idle_cnt <= '0;
        else        idle_cnt <= idle_cnt_n;
    end
`else
    assign timeout = 1'b0;
`endif

    always_comb begin
        state_n    = state;
        bal_n      = balance;
        price_n    = price_lat;
        chg_n      = change_amt;
        sel_err_n  = 1'b0;
        coin_rej_n = 1'b0;
        case (state)
            ST_IDLE: begin
                coin_rej_n = coin_valid;
                if (sel_valid) begin
                    if (product_price != 8'd0) begin
                        price_n = product_price;
                        bal_n   = 8'd0;
                        state_n = ST_COLLECT;
                    end else begin
                        sel_err_n = 1'b1;
                    end
                end
            end
            ST_COLLECT: begin
                if (cancel || timeout) begin
                    coin_rej_n = coin_valid;
                    if (balance != 8'd0) begin
                        chg_n   = balance;
                        state_n = ST_CHANGE;
                    end else begin
                        state_n = ST_IDLE;
                    end
                end else if (coin_valid) begin
                    if (coin_ok) begin
                        bal_n = sum[7:0];
                        if (sum[7:0] >= price_lat) begin
                            chg_n   = sum[7:0] - price_lat;
                            state_n = ST_DISPENSE;
                        end
                    end else begin
                        coin_rej_n = 1'b1;
                    end
                end
            end
            ST_DISPENSE: begin
                coin_rej_n = coin_valid;
                if (change_amt != 8'd0) begin
                    state_n = ST_CHANGE;
                end else begin
                    state_n = ST_IDLE;
                    bal_n   = 8'd0;
                end
            end
            default: begin
                coin_rej_n = coin_valid;
                state_n    = ST_IDLE;
                bal_n      = 8'd0;
                chg_n      = 8'd0;
            end
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state      <= ST_IDLE;
            balance    <= 8'd0;
            price_lat  <= 8'd0;
            change_amt <= 8'd0;
            sel_err    <= 1'b0;
            coin_rej   <= 1'b0;
        end else begin
            state      <= state_n;
            balance    <= bal_n;
            price_lat  <= price_n;
            change_amt <= chg_n;
            sel_err    <= sel_err_n;
            coin_rej   <= coin_rej_n;
        end
    end

    assign busy         = (state != ST_IDLE);
    assign dispense     = (state == ST_DISPENSE);
    assign change_valid = (state == ST_CHANGE);

endmodule

// File: tb/tb_vend_payment_fsm.sv
// Self-checking bench for vend_payment_fsm: directed scenarios plus randomized traffic
// checked against a transaction-queue reference model.
module tb_vend_payment_fsm;

    localparam int TO = 16;

    logic       clk = 1'b0;
    logic       rst_n;
    logic [7:0] product_price;
    logic       sel_valid, coin_valid, cancel;
    logic [3:0] coin_code;
    logic       busy, dispense, change_valid, sel_err, coin_rej;
    logic [7:0] price_lat, balance, change_amt;

    int checks = 0;
    int errors = 0;

    always #5 clk = ~clk;

    vend_payment_fsm #(.TIMEOUT_CYCLES(TO)) dut (
        .clk           (clk),
        .rst_n         (rst_n),
        .product_price (product_price),
        .sel_valid     (sel_valid),
        .coin_valid    (coin_valid),
        .coin_code     (coin_code),
        .cancel        (cancel),
        .busy          (busy),
        .price_lat     (price_lat),
        .balance       (balance),
        .dispense      (dispense),
        .change_valid  (change_valid),
        .change_amt    (change_amt),
        .sel_err       (sel_err),
        .coin_rej      (coin_rej)
    );

    // Reference model: pending output phases after a purchase/refund live in a queue.
    typedef struct { bit disp; bit chg; int amt; } ev_t;
    ev_t q[$];
    bit  m_active, m_serr, m_rej;
    int  m_price, m_bal, m_idle;

    function automatic int coin_val(logic [3:0] c);
        case (c)
            4'b0001: return 1;
            4'b0010: return 2;
            4'b0100: return 5;
            4'b1000: return 10;
            default: return -1;
        endcase
    endfunction

    task automatic model_reset();
        q.delete();
        m_active = 0; m_serr = 0; m_rej = 0;
        m_price = 0; m_bal = 0; m_idle = 0;
    endtask

    task automatic model_step(bit sv, int pp, bit cv, logic [3:0] cc, bit cn);
        int v;
        bit credited, refund;
        m_serr = 0;
        m_rej  = 0;
        if (q.size() > 0) begin
            m_rej = cv;
            q.delete(0);
            if (q.size() == 0) m_bal = 0;
        end else if (!m_active) begin
            m_rej = cv;
            if (sv) begin
                if (pp != 0) begin
                    m_active = 1; m_price = pp; m_bal = 0; m_idle = 0;
                end else begin
                    m_serr = 1;
                end
            end
        end else begin
            v        = cv ? coin_val(cc) : -1;
            credited = cv && !cn && (v >= 0) && (m_bal + v <= 255);
            refund   = cn;
`ifdef VEND_TIMEOUT_EN
            if (!credited && m_idle == TO - 1) refund = 1;
            m_idle = credited ? 0 : m_idle + 1;
`endif
            if (refund) begin
                m_rej    = cv;
                m_active = 0;
                if (m_bal != 0) q.push_back('{disp: 0, chg: 1, amt: m_bal});
            end else if (cv) begin
                if (credited) begin
                    m_bal += v;
                    if (m_bal >= m_price) begin
                        m_active = 0;
                        q.push_back('{disp: 1, chg: 0, amt: m_bal - m_price});
                        if (m_bal != m_price)
                            q.push_back('{disp: 0, chg: 1, amt: m_bal - m_price});
                    end
                end else begin
                    m_rej = 1;
                end
            end
        end
    endtask

    // Drive one cycle of inputs from posedge+1, advance the model, sample at the next posedge+1.
    task automatic tick(bit sv, int pp, bit cv, logic [3:0] cc, bit cn);
        sel_valid     = sv;
        product_price = pp[7:0];
        coin_valid    = cv;
        coin_code     = cc;
        cancel        = cn;
        model_step(sv, pp, cv, cc, cn);
        @(posedge clk);
        #1;
        sel_valid  = 0;
        coin_valid = 0;
        cancel     = 0;
    endtask

    task automatic test_reset();
        rst_n = 0;
        @(posedge clk); #1;
        checks++;
        if ({busy, price_lat, balance, dispense, change_valid, change_amt, sel_err, coin_rej} !== '0) begin
            errors++;
            $display("FAIL reset_outputs: got busy=%0b price=%0d bal=%0d disp=%0b chg=%0b amt=%0d serr=%0b rej=%0b, want all 0",
                     busy, price_lat, balance, dispense, change_valid, change_amt, sel_err, coin_rej);
        end
        rst_n = 1;
        model_reset();
    endtask

    task automatic test_exact();
        tick(1, 5, 0, 0, 0);
        checks++;
        if (busy !== 1'b1 || price_lat !== 8'd5) begin
            errors++; $display("FAIL exact_select: busy=%0b price=%0d, want 1/5", busy, price_lat);
        end
        tick(0, 0, 1, 4'b0100, 0);
        checks++;
        if (balance !== 8'd5 || dispense !== 1'b1 || change_valid !== 1'b0) begin
            errors++; $display("FAIL exact_dispense: bal=%0d disp=%0b chg=%0b, want 5/1/0", balance, dispense, change_valid);
        end
        tick(0, 0, 0, 0, 0);
        checks++;
        if (busy !== 1'b0 || change_valid !== 1'b0 || dispense !== 1'b0) begin
            errors++; $display("FAIL exact_done: busy=%0b chg=%0b disp=%0b, want 0/0/0", busy, change_valid, dispense);
        end
    endtask

    task automatic test_overpay();
        tick(1, 2, 0, 0, 0);
        tick(0, 0, 1, 4'b0001, 0);
        checks++;
        if (balance !== 8'd1 || dispense !== 1'b0) begin
            errors++; $display("FAIL overpay_first: bal=%0d disp=%0b, want 1/0", balance, dispense);
        end
        tick(0, 0, 1, 4'b1000, 0);
        checks++;
        if (balance !== 8'd11 || dispense !== 1'b1 || change_amt !== 8'd9) begin
            errors++; $display("FAIL overpay_dispense: bal=%0d disp=%0b amt=%0d, want 11/1/9", balance, dispense, change_amt);
        end
        tick(0, 0, 1, 4'b0001, 0);
        checks++;
        if (change_valid !== 1'b1 || change_amt !== 8'd9 || coin_rej !== 1'b1 || balance !== 8'd11) begin
            errors++; $display("FAIL overpay_change: chg=%0b amt=%0d rej=%0b bal=%0d, want 1/9/1/11",
                               change_valid, change_amt, coin_rej, balance);
        end
        tick(0, 0, 0, 0, 0);
        checks++;
        if (busy !== 1'b0 || balance !== 8'd0) begin
            errors++; $display("FAIL overpay_idle: busy=%0b bal=%0d, want 0/0", busy, balance);
        end
    endtask

    task automatic test_cancel();
        tick(1, 10, 0, 0, 0);
        tick(0, 0, 1, 4'b0010, 0);
        tick(0, 0, 1, 4'b0100, 0);
        checks++;
        if (balance !== 8'd7) begin
            errors++; $display("FAIL cancel_balance: bal=%0d, want 7", balance);
        end
        tick(0, 0, 0, 0, 1);
        checks++;
        if (change_valid !== 1'b1 || change_amt !== 8'd7 || dispense !== 1'b0) begin
            errors++; $display("FAIL cancel_refund: chg=%0b amt=%0d disp=%0b, want 1/7/0", change_valid, change_amt, dispense);
        end
        tick(0, 0, 0, 0, 0);
        tick(1, 10, 0, 0, 0);
        tick(0, 0, 1, 4'b0010, 0);
        tick(0, 0, 1, 4'b0100, 1);
        checks++;
        if (change_valid !== 1'b1 || change_amt !== 8'd2 || coin_rej !== 1'b1) begin
            errors++; $display("FAIL cancel_with_coin: chg=%0b amt=%0d rej=%0b, want 1/2/1", change_valid, change_amt, coin_rej);
        end
        tick(0, 0, 0, 0, 0);
        checks++;
        if (busy !== 1'b0) begin
            errors++; $display("FAIL cancel_idle: busy=%0b, want 0", busy);
        end
    endtask

    task automatic test_errors();
        tick(1, 0, 0, 0, 0);
        checks++;
        if (sel_err !== 1'b1 || busy !== 1'b0) begin
            errors++; $display("FAIL sel_zero: serr=%0b busy=%0b, want 1/0", sel_err, busy);
        end
        tick(0, 0, 1, 4'b0001, 0);
        checks++;
        if (coin_rej !== 1'b1 || busy !== 1'b0 || balance !== 8'd0) begin
            errors++; $display("FAIL coin_idle: rej=%0b busy=%0b bal=%0d, want 1/0/0", coin_rej, busy, balance);
        end
        tick(1, 10, 0, 0, 0);
        tick(0, 0, 1, 4'b0011, 0);
        checks++;
        if (coin_rej !== 1'b1 || balance !== 8'd0 || busy !== 1'b1) begin
            errors++; $display("FAIL coin_invalid: rej=%0b bal=%0d busy=%0b, want 1/0/1", coin_rej, balance, busy);
        end
        tick(1, 3, 0, 0, 1);
        checks++;
        if (busy !== 1'b0 || change_valid !== 1'b0 || price_lat !== 8'd10) begin
            errors++; $display("FAIL cancel_empty: busy=%0b chg=%0b price=%0d, want 0/0/10", busy, change_valid, price_lat);
        end
    endtask

    task automatic test_saturation();
        tick(1, 255, 0, 0, 0);
        for (int i = 0; i < 25; i++) begin
            tick(0, 0, 1, 4'b1000, 0);
            checks++;
            if (balance !== 8'(10 * (i + 1)) || dispense !== 1'b0) begin
                errors++; $display("FAIL sat_accum[%0d]: bal=%0d disp=%0b, want %0d/0", i, balance, dispense, 10 * (i + 1));
            end
        end
        tick(0, 0, 1, 4'b1000, 0);
        checks++;
        if (coin_rej !== 1'b1 || balance !== 8'd250) begin
            errors++; $display("FAIL sat_overflow: rej=%0b bal=%0d, want 1/250", coin_rej, balance);
        end
        tick(0, 0, 1, 4'b0100, 0);
        checks++;
        if (balance !== 8'd255 || dispense !== 1'b1 || coin_rej !== 1'b0) begin
            errors++; $display("FAIL sat_fill: bal=%0d disp=%0b rej=%0b, want 255/1/0", balance, dispense, coin_rej);
        end
        tick(0, 0, 0, 0, 0);
        checks++;
        if (busy !== 1'b0 || change_valid !== 1'b0) begin
            errors++; $display("FAIL sat_done: busy=%0b chg=%0b, want 0/0", busy, change_valid);
        end
    endtask

`ifdef VEND_TIMEOUT_EN
    task automatic test_timeout();
        tick(1, 10, 0, 0, 0);
        tick(0, 0, 1, 4'b0010, 0);
        for (int i = 1; i < TO; i++) begin
            tick(0, 0, 0, 0, 0);
            checks++;
            if (busy !== 1'b1 || change_valid !== 1'b0) begin
                errors++; $display("FAIL timeout_wait[%0d]: busy=%0b chg=%0b, want 1/0", i, busy, change_valid);
            end
        end
        tick(0, 0, 0, 0, 0);
        checks++;
        if (change_valid !== 1'b1 || change_amt !== 8'd2) begin
            errors++; $display("FAIL timeout_refund: chg=%0b amt=%0d, want 1/2", change_valid, change_amt);
        end
        tick(0, 0, 0, 0, 0);
    endtask
`endif

    task automatic test_reset_mid();
        tick(1, 10, 0, 0, 0);
        tick(0, 0, 1, 4'b0010, 0);
        rst_n = 0;
        #1;
        checks++;
        if ({busy, price_lat, balance, dispense, change_valid, change_amt, sel_err, coin_rej} !== '0) begin
            errors++; $display("FAIL reset_mid: busy=%0b price=%0d bal=%0d chg=%0b, want all 0",
                               busy, price_lat, balance, change_valid);
        end
        for (int i = 0; i < 2; i++) begin
            @(posedge clk); #1;
            checks++;
            if (change_valid !== 1'b0 || busy !== 1'b0) begin
                errors++; $display("FAIL reset_hold[%0d]: chg=%0b busy=%0b, want 0/0", i, change_valid, busy);
            end
        end
        rst_n = 1;
        model_reset();
        tick(0, 0, 0, 0, 0);
        checks++;
        if (busy !== 1'b0 || change_valid !== 1'b0 || balance !== 8'd0) begin
            errors++; $display("FAIL reset_release: busy=%0b chg=%0b bal=%0d, want 0/0/0", busy, change_valid, balance);
        end
    endtask

    task automatic test_random();
        logic [3:0] codes [4];
        bit         sv, cv, cn;
        int         pp;
        logic [3:0] cc;
        codes[0] = 4'b0001; codes[1] = 4'b0010; codes[2] = 4'b0100; codes[3] = 4'b1000;
        for (int i = 0; i < 800; i++) begin
            sv = ($urandom_range(0, 5) == 0);
            pp = ($urandom_range(0, 6) == 0) ? 0 : int'($urandom_range(1, 40));
            cv = ($urandom_range(0, 2) == 0);
            cc = ($urandom_range(0, 6) == 0) ? 4'($urandom) : codes[$urandom_range(0, 3)];
            cn = ($urandom_range(0, 30) == 0);
            tick(sv, pp, cv, cc, cn);
            checks++;
            if (busy !== (m_active || q.size() > 0) || balance !== 8'(m_bal) || price_lat !== 8'(m_price)) begin
                errors++; $display("FAIL rand_state[%0d]: busy=%0b bal=%0d price=%0d, want %0b/%0d/%0d",
                                   i, busy, balance, price_lat, (m_active || q.size() > 0), m_bal, m_price);
            end
            checks++;
            if (sel_err !== m_serr || coin_rej !== m_rej) begin
                errors++; $display("FAIL rand_errs[%0d]: serr=%0b rej=%0b, want %0b/%0b", i, sel_err, coin_rej, m_serr, m_rej);
            end
            checks++;
            if (q.size() > 0) begin
                if (dispense !== q[0].disp || change_valid !== q[0].chg || change_amt !== 8'(q[0].amt)) begin
                    errors++; $display("FAIL rand_pulse[%0d]: disp=%0b chg=%0b amt=%0d, want %0b/%0b/%0d",
                                       i, dispense, change_valid, change_amt, q[0].disp, q[0].chg, q[0].amt);
                end
            end else if (dispense !== 1'b0 || change_valid !== 1'b0) begin
                errors++; $display("FAIL rand_nopulse[%0d]: disp=%0b chg=%0b, want 0/0", i, dispense, change_valid);
            end
        end
        for (int i = 0; i < 3; i++) tick(0, 0, 0, 0, 1);
    endtask

    initial begin
        rst_n         = 0;
        product_price = 0;
        sel_valid     = 0;
        coin_valid    = 0;
        coin_code     = 0;
        cancel        = 0;
        model_reset();
        test_reset();
        test_exact();
        test_overpay();
        test_cancel();
        test_errors();
        test_saturation();
`ifdef VEND_TIMEOUT_EN
        test_timeout();
`endif
        test_reset_mid();
        test_random();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

// File: doc/vend_payment_fsm.md
# vend_payment_fsm

Payment controller for the vending machine, directly downstream of the product-code-to-price lookup. It latches the registered product price on a selection strobe and accumulates one-hot coded coins until the price is covered. It then issues a one-cycle dispense pulse and returns any overpayment as change. Cancel and an optional inactivity timeout refund the collected balance.

## Interface
- TIMEOUT_CYCLES, 1024: COLLECT inactivity limit in clk cycles (used only with VEND_TIMEOUT_EN); must be ≥2.
- clk  in  1  system clock, rising edge.
- rst_n  in  1  asynchronous active-low reset.
- product_price  in  8  price from the lookup stage, unsigned; 0 = invalid code.
- sel_valid  in  1  one-cycle strobe; product_price is valid in this cycle.
- coin_valid  in  1  one-cycle strobe, coin present on coin_code.
- coin_code  in  4  coin code: 0001=1, 0010=2, 0100=5, 1000=10; any other code is invalid.
- cancel  in  1  level/pulse, refund request.
- busy  out  1  high in any state other than IDLE.
- price_lat  out  8  latched price.
- balance  out  8  credited amount.
- dispense  out  1  one-cycle pulse, vend product.
- change_valid  out  1  one-cycle pulse; change_amt valid.
- change_amt  out  8  change/refund amount.
- sel_err  out  1  one-cycle pulse, selection with price 0.
- coin_rej  out  1  one-cycle pulse, coin not credited.

## Operation
- States: IDLE, COLLECT, DISPENSE, CHANGE.
- IDLE:
  - sel_valid with price≠0: latch price, clear balance, go to COLLECT.
  - sel_valid with price=0: pulse sel_err and stay in IDLE.
  - Coins: rejected (coin_rej).
- COLLECT:
  - Valid coin: balance += value.
  - Invalid code, or a sum that would exceed 255: pulse coin_rej; balance unchanged.
  - When the updated balance ≥ price_lat: go to DISPENSE.
  - cancel: go to CHANGE with change_amt = balance, or to IDLE if balance = 0.
  - cancel together with coin_valid: cancel wins and the coin is rejected.
  - sel_valid is ignored in every state except IDLE.
- DISPENSE: lasts 1 cycle with dispense=1 and change_amt = balance − price_lat. Go to CHANGE if the difference is nonzero, else go to IDLE.
- CHANGE: lasts 1 cycle with change_valid=1, then go to IDLE. balance clears on entry to IDLE.
- Arithmetic: the adder is 9 bits internally; the compare is unsigned 8-bit; subtraction never underflows because DISPENSE implies balance ≥ price.

## Timing
- Reset values: all outputs 0, state IDLE, internal counters 0.
- Reset asserted mid-transaction clears the state with no refund pulse.
- All outputs are registered. dispense and change_valid are Moore decodes of registered state.
- Selection: sel_valid at cycle n → busy=1 and price_lat valid at n+1.
- Coin: coin at n → balance updated at n+1.
- Covering coin at n → dispense=1 at n+1, change_valid=1 at n+2 (if change is nonzero), busy=0 at n+2 or n+3.
- Coins arriving during DISPENSE or CHANGE are rejected (coin_rej at the next cycle).
- Error pulses sel_err and coin_rej occur one cycle after the offending strobe.

## Configuration
- Macro: VEND_TIMEOUT_EN.
- Defined: a counter runs in COLLECT and clears on entry and on every credited coin. On reaching TIMEOUT_CYCLES−1 with no activity, the block behaves exactly as cancel (refund via CHANGE, or IDLE if balance = 0).
- A coin credited in the terminal-count cycle restarts the counter; it has priority over the timeout.
- Undefined: no counter; COLLECT waits indefinitely. TIMEOUT_CYCLES is unused.

## Structure
- Package vend_pkg:
  - state enum
  - coin code localparams (COIN_1, COIN_2, COIN_5, COIN_10)
  - coin value widths
- The upstream lookup stage shares the same code constants.
- Sub-module vend_coin_decode: combinational coin_code → {valid, value[3:0]}. It is instantiated once.
- FSM and datapath stay in vend_payment_fsm.

## Test plan
- Exact payment: select price 5 and insert coin 0100 → balance=5, dispense pulse the next cycle, no change_valid, busy drops.
- Overpay: select price 2 and insert 0001 then 1000 → balance 1 then 11; dispense; change_valid with change_amt=9.
- Cancel: price 10, coins 0010 and 0100 (balance 7), then cancel → change_valid with change_amt=7 and no dispense. Cancel concurrent with a coin → coin_rej, and the refund excludes that coin.
- Errors: sel_valid with price 0 → sel_err with busy=0. coin_code 0011 in COLLECT → coin_rej and balance unchanged. A coin in IDLE → coin_rej.
- Saturation: price 255 with repeated 1000 coins up to balance 250, then another 1000 → coin_rej; then 0100 → balance 255 and dispense.
- Timeout (with VEND_TIMEOUT_EN, TIMEOUT_CYCLES=16): price 10 plus coin 0010, then idle → refund of 2 after 16 idle cycles. Reset mid-COLLECT → all outputs 0 and no change_valid.
